// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: EX-stage sequencer for the multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Define DIV_REUSE_EN to add a one-entry buffer that answers a repeated {a, b, signedness} without the divider.
module div_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [TAG_WIDTH-1:0]  req_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_rd,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_a,
    output logic [DATA_WIDTH-1:0] div_b,
    output logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] div_q,
    input  logic [DATA_WIDTH-1:0] div_r,
    input  logic                  div_ready,
    output logic [2:0]            dbg_state
);

    // Handshakes: EX holds req_valid (and its operands) until stall drops; a request is taken in
    // IDLE when req_valid & ~flush. div_start is a one-cycle command, div_ready a level completion
    // that is only trusted from the cycle after div_start. resp_valid is a one-cycle strobe.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  sel_rem;
    logic [TAG_WIDTH-1:0]  rd_q;
    logic                  accept;
    logic                  wait_done;
    logic                  reuse_hit;
    logic [DATA_WIDTH-1:0] reuse_q;
    logic [DATA_WIDTH-1:0] reuse_r;

    assign accept    = (state == S_IDLE) && req_valid && !flush;
    assign wait_done = (state == S_WAIT) && div_ready && !flush;
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = reuse_hit ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // A flush that coincides with completion has nothing left to drain.
                if (flush) begin
                    state_nxt = div_ready ? S_IDLE : S_DRAIN;
                end else if (div_ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (div_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        div_start  = 1'b0;
        resp_valid = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                stall = req_valid && !flush;
            end
            S_ISSUE: begin
                div_start = !flush;
                stall     = 1'b1;
            end
            S_WAIT: begin
                stall = 1'b1;
            end
            S_DONE: begin
                resp_valid = !flush;
            end
            S_DRAIN: begin
                stall = req_valid;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Request capture; the divider operands stay put until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_rem    <= 1'b0;
            rd_q       <= '0;
            div_a      <= '0;
            div_b      <= '0;
            div_signed <= 1'b0;
        end else if (accept) begin
            sel_rem    <= req_op[1];
            rd_q       <= req_rd;
            div_a      <= req_a;
            div_b      <= req_b;
            div_signed <= ~req_op[0];
        end
    end

    // Result registers, loaded on entry to DONE and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
            resp_rd   <= '0;
        end else if (wait_done) begin
            resp_data <= sel_rem ? div_r : div_q;
            resp_rd   <= rd_q;
        end else if (accept && reuse_hit) begin
            resp_data <= req_op[1] ? reuse_r : reuse_q;
            resp_rd   <= req_rd;
        end
    end

`ifdef DIV_REUSE_EN
    logic                  rb_valid;
    logic [DATA_WIDTH-1:0] rb_a;
    logic [DATA_WIDTH-1:0] rb_b;
    logic                  rb_signed;
    logic [DATA_WIDTH-1:0] rb_q;
    logic [DATA_WIDTH-1:0] rb_r;

    // Both q and r are kept so a DIV followed by REM of the same operands hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_valid  <= 1'b0;
            rb_a      <= '0;
            rb_b      <= '0;
            rb_signed <= 1'b0;
            rb_q      <= '0;
            rb_r      <= '0;
        end else if (wait_done) begin
            rb_valid  <= 1'b1;
            rb_a      <= div_a;
            rb_b      <= div_b;
            rb_signed <= div_signed;
            rb_q      <= div_q;
            rb_r      <= div_r;
        end
    end

    assign reuse_hit = rb_valid && (rb_a == req_a) && (rb_b == req_b) && (rb_signed == ~req_op[0]);
    assign reuse_q   = rb_q;
    assign reuse_r   = rb_r;
`else
    assign reuse_hit = 1'b0;
    assign reuse_q   = '0;
    assign reuse_r   = '0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized self-checking bench for div_seq_ctrl with a behavioural divider
// and a reference model of RV32M results, reuse hits and latencies.
module tb_div_seq_ctrl;
  localparam int W = 32;
  localparam int TW = 5;
  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [TW-1:0] req_rd = '0;
  logic flush = 1'b0;
  logic stall;
  logic resp_valid;
  logic [W-1:0] resp_data;
  logic [TW-1:0] resp_rd;
  logic div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic div_signed;
  logic [W-1:0] div_q = '0;
  logic [W-1:0] div_r = '0;
  logic div_ready = 1'b1;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [TW-1:0] exp_rd_q[$];
  logic [W-1:0] last_data = '0;
  logic [TW-1:0] last_rd = '0;
  int div_lat = 33;

  // Reference reuse entry
  bit rb_v = 1'b0;
  logic [W-1:0] rb_a = '0;
  logic [W-1:0] rb_b = '0;
  logic rb_s = 1'b0;

  // Behavioural divider state
  int m_cnt = 0;
  bit start_seen = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic m_s = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  int proto_err = 0;

  div_seq_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_rd(req_rd), .flush(flush), .stall(stall), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_rd(resp_rd), .div_start(div_start), .div_a(div_a),
    .div_b(div_b), .div_signed(div_signed), .div_q(div_q), .div_r(div_r),
    .div_ready(div_ready), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // RV32M arithmetic
  function automatic logic [W-1:0] ref_q(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    if (s) begin
      if (a == 32'h8000_0000 && b == '1) return a;
      return W'($signed(a) / $signed(b));
    end
    return a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return a;
    if (s) begin
      if (a == 32'h8000_0000 && b == '1) return '0;
      return W'($signed(a) % $signed(b));
    end
    return a % b;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return op[1] ? ref_r(~op[0], a, b) : ref_q(~op[0], a, b);
  endfunction

  function automatic bit model_hit(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_REUSE_EN
    return rb_v && (rb_a == a) && (rb_b == b) && (rb_s == ~op[0]);
`else
    return 1'b0;
`endif
  endfunction

  // Divider: busy for div_lat cycles (1 for a zero divisor); ready is a level, stale-high when idle.
  always @(negedge clk) begin
    if (div_start === 1'b1) begin
      start_seen = 1'b1;
      m_a = div_a;
      m_b = div_b;
      m_s = div_signed;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      start_seen = 1'b0;
    end else if (start_seen) begin
      if (m_cnt != 0) proto_err++;
      m_q = ref_q(m_s, m_a, m_b);
      m_r = ref_r(m_s, m_a, m_b);
      m_cnt = (m_b == '0) ? 0 : div_lat - 1;
      start_seen = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
    #1;
    div_ready = (m_cnt == 0);
    div_q = div_ready ? m_q : W'($urandom);
    div_r = div_ready ? m_r : W'($urandom);
  end

  // Waits for the response of an already-presented request and scores it.
  task automatic wait_resp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] rd, input bit hit, input int lat);
    int k;
    int n_start;
    bit got;
    bit hold_ok;
    bit stall_ok;
    bit start_ok;
    logic [W-1:0] exp_d;
    logic [TW-1:0] exp_r;
    exp_q.push_back(ref_result(op, a, b));
    exp_rd_q.push_back(rd);
    k = 0; n_start = 0; got = 1'b0; hold_ok = 1'b1; stall_ok = 1'b1; start_ok = 1'b1;
    @(negedge clk);
    while (!got && k <= BUDGET) begin
      if (resp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (stall !== 1'b1) stall_ok = 1'b0;
        if (resp_data !== last_data || resp_rd !== last_rd) hold_ok = 1'b0;
        if (div_start === 1'b1) begin
          n_start++;
          if (div_a !== a || div_b !== b || div_signed !== ~op[0]) start_ok = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    exp_d = exp_q.pop_front();
    exp_r = exp_rd_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout op=%0d a=%h b=%h: no resp_valid within %0d cycles", op, a, b, BUDGET);
    end else begin
      if (lat >= 0) begin
        checks++;
        if (k !== lat) begin
          errors++;
          $display("FAIL latency op=%0d a=%h b=%h: got %0d cycles, expected %0d", op, a, b, k, lat);
        end
      end
      checks++;
      if (resp_data !== exp_d) begin
        errors++;
        $display("FAIL resp_data op=%0d a=%h b=%h: got %h expected %h", op, a, b, resp_data, exp_d);
      end
      checks++;
      if (resp_rd !== exp_r) begin
        errors++;
        $display("FAIL resp_rd: got %0d expected %0d", resp_rd, exp_r);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL stall_done: got %b expected 0", stall);
      end
      checks++;
      if (n_start !== (hit ? 0 : 1)) begin
        errors++;
        $display("FAIL start_count op=%0d a=%h b=%h: got %0d expected %0d", op, a, b, n_start, hit ? 0 : 1);
      end
      checks++;
      if (!start_ok) begin
        errors++;
        $display("FAIL start_operands: div_a/div_b/div_signed got %h/%h/%b expected %h/%h/%b", div_a, div_b, div_signed, a, b, ~op[0]);
      end
      last_data = exp_d;
      last_rd = exp_r;
      if (!hit) begin
        rb_v = 1'b1; rb_a = a; rb_b = b; rb_s = ~op[0];
      end
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL stall_busy: stall got 0 expected 1 while busy (op=%0d a=%h b=%h)", op, a, b);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL resp_hold: resp_data/rd changed before DONE, got %h/%0d expected %h/%0d", resp_data, resp_rd, last_data, last_rd);
    end
  endtask

  // Driver: presents one request in the next cycle and holds it until DONE.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] rd);
    bit hit;
    int lat;
    hit = model_hit(op, a, b);
    lat = hit ? 1 : 2 + ((b == '0) ? 1 : div_lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    wait_resp(op, a, b, rd, hit, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || resp_valid !== 1'b0 || div_start !== 1'b0 || div_signed !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: stall/resp_valid/div_start/div_signed got %b%b%b%b expected 0000", stall, resp_valid, div_start, div_signed);
    end
    checks++;
    if (div_a !== '0 || div_b !== '0 || resp_data !== '0 || resp_rd !== '0) begin
      errors++;
      $display("FAIL reset_data: div_a/div_b/resp_data/resp_rd got %h/%h/%h/%0d expected 0", div_a, div_b, resp_data, resp_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_stall: got %b expected 0", stall);
    end
  endtask

  task automatic test_divu_basic;
    div_lat = 33;
    run_op(2'b01, 32'd100, 32'd7, 5'd3);
  endtask

  task automatic test_rem_signed;
    div_lat = 33;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
  endtask

  task automatic test_div_zero;
    div_lat = 33;
    run_op(2'b00, 32'd12345, 32'd0, 5'd6);
    run_op(2'b11, 32'd12345, 32'd0, 5'd7);
  endtask

  task automatic test_flush_issue;
    bit quiet;
    div_lat = 33;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd40; req_b = 32'd4; req_rd = 5'd8;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (div_start !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue_start: got %b expected 0", div_start);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (div_start !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL flush_issue_idle: start/resp/stall got %b%b%b expected 000", div_start, resp_valid, stall);
    end
  endtask

  task automatic test_flush_wait;
    div_lat = 33;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1000; req_b = 32'd7; req_rd = 5'd9;
    repeat (6) @(posedge clk);
    #1;
    flush = 1'b1; req_op = 2'b01; req_a = 32'd9; req_b = 32'd3; req_rd = 5'd10;
    fork
      begin
        @(posedge clk); #1;
        flush = 1'b0;
      end
    join_none
    wait_resp(2'b01, 32'd9, 32'd3, 5'd10, model_hit(2'b01, 32'd9, 32'd3), -1);
  endtask

  task automatic test_flush_done;
    div_lat = 33;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd20; req_b = 32'd0; req_rd = 5'd13;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_gate: resp_valid got %b expected 0", resp_valid);
    end
    checks++;
    if (resp_data !== 32'hFFFF_FFFF || resp_rd !== 5'd13) begin
      errors++;
      $display("FAIL flush_done_regs: got %h/%0d expected ffffffff/13", resp_data, resp_rd);
    end
    last_data = 32'hFFFF_FFFF; last_rd = 5'd13;
    rb_v = 1'b1; rb_a = 32'd20; rb_b = 32'd0; rb_s = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_after: resp_valid/stall got %b%b expected 00", resp_valid, stall);
    end
  endtask

  task automatic test_flush_ready_same;
    bit quiet;
    div_lat = 33;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd5; req_b = 32'd0; req_rd = 5'd11;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || stall !== 1'b0 || resp_data !== last_data || resp_rd !== last_rd) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL flush_ready_discard: resp_valid/stall %b%b data %h/%0d expected 00 %h/%0d", resp_valid, stall, resp_data, resp_rd, last_data, last_rd);
    end
    run_op(2'b00, 32'd5, 32'd0, 5'd12);
  endtask

  task automatic test_reset_mid_wait;
    div_lat = 33;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd77; req_b = 32'd5; req_rd = 5'd14;
    repeat (5) @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || resp_valid !== 1'b0 || div_start !== 1'b0 || div_signed !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_ctrl: stall/resp_valid/div_start/div_signed got %b%b%b%b expected 0000", stall, resp_valid, div_start, div_signed);
    end
    checks++;
    if (div_a !== '0 || div_b !== '0 || resp_data !== '0 || resp_rd !== '0) begin
      errors++;
      $display("FAIL rst_wait_data: div_a/div_b/resp_data/resp_rd got %h/%h/%h/%0d expected 0", div_a, div_b, resp_data, resp_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rb_v = 1'b0; last_data = '0; last_rd = '0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_idle: stall/resp_valid got %b%b expected 00", stall, resp_valid);
    end
  endtask

  task automatic test_reuse;
    div_lat = 33;
    run_op(2'b00, 32'd50, 32'd6, 5'd1);
    run_op(2'b10, 32'd50, 32'd6, 5'd2);
    run_op(2'b10, 32'd50, 32'd7, 5'd3);
  endtask

  function automatic logic [W-1:0] pick_a();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd50;
      4: return 32'hFFFF_FFF9;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] pick_b();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'd6;
      3: return 32'd7;
      4: return 32'd1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_back_to_back;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_a();
      b = pick_b();
      div_lat = $urandom_range(1, 40);
      run_op(op, a, b, TW'($urandom));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_rem_signed();
    test_div_zero();
    test_flush_issue();
    test_flush_wait();
    test_flush_done();
    test_flush_ready_same();
    test_reset_mid_wait();
    test_reuse();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL divider_reissue: got %0d starts while busy expected 0", proto_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
